// File: rtl/alien_fire_ctrl_pkg.sv
// Shared types and screen constants for the alien firing controller.
package alien_fire_ctrl_pkg;
    localparam int HRES = 640;
    localparam int VRES = 480;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {FC_COUNT, FC_SEARCH, FC_FIRE, FC_WAIT} fire_state_t;

    // Saturate a 13-bit sum at lim so off-screen spawns pin to the edge instead of wrapping.
    function automatic logic [11:0] clamp12(input logic [12:0] v, input logic [11:0] lim);
        return (v > {1'b0, lim}) ? lim : v[11:0];
    endfunction
endpackage

// File: rtl/alien_fire_ctrl_lfsr16.sv
// 16-bit Galois LFSR that advances only when step is high; reset loads SEED.
module lfsr16
    import alien_fire_ctrl_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic        step,
    output logic [15:0] q
);
    logic [15:0] r_q;

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            r_q <= SEED;
        end else if (step) begin
            r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign q = r_q;
endmodule

// File: rtl/alien_fire_ctrl.sv
// Decides when the alien formation shoots and which live column fires.
// Optional build macro ALIEN_FIRE_AIM_EN adds player_x and aims the column search at the player.
module alien_fire_ctrl
    import alien_fire_ctrl_pkg::*;
#(
    parameter int          NUM_ALIENS    = 8,
    parameter int          ALIEN_SPACING = 64,
    parameter int          ALIEN_W       = 32,
    parameter int          ALIEN_H       = 24,
    parameter int          MIN_INTERVAL  = 30,
    parameter logic [7:0]  INTERVAL_MASK = 8'h3F,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                          pixel_clk,
    input  logic                          rst_n,
    input  logic                          fsync,
    input  logic                          enable,
    input  logic [NUM_ALIENS-1:0]         alive_mask,
    input  logic [11:0]                   form_x,
    input  logic [11:0]                   form_y,
`ifdef ALIEN_FIRE_AIM_EN
    input  logic [11:0]                   player_x,
`endif
    input  logic                          bullet_active,
    output logic                          fire,
    output logic [11:0]                   alien_x,
    output logic [11:0]                   alien_y,
    output logic [$clog2(NUM_ALIENS)-1:0] shooter_idx,
    output fire_state_t                   dbg_state,
    output logic [15:0]                   dbg_lfsr
);
    localparam int IW    = $clog2(NUM_ALIENS);
    localparam int SP_SH = $clog2(ALIEN_SPACING);

    fire_state_t   r_state;
    logic [8:0]    r_countdown;
    logic [IW-1:0] r_idx;
    logic          r_wait_fsync;
    logic          r_fire;
    logic [11:0]   r_alien_x;
    logic [11:0]   r_alien_y;
    logic [IW-1:0] r_shooter_idx;

    logic [15:0]   w_lfsr;
    logic [IW-1:0] w_start_idx;
    logic [8:0]    w_reload;
    logic [12:0]   w_x13;
    logic [12:0]   w_y13;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .step      (fsync),
        .q         (w_lfsr)
    );

`ifdef ALIEN_FIRE_AIM_EN
    logic [11:0] w_rel;
    logic [11:0] w_col;

    // Column under the player, saturated to the formation's extent on either side.
    always_comb begin
        w_rel = player_x - form_x;
        w_col = w_rel >> SP_SH;
        if (player_x < form_x) begin
            w_start_idx = '0;
        end else if (w_col > 12'(NUM_ALIENS - 1)) begin
            w_start_idx = IW'(NUM_ALIENS - 1);
        end else begin
            w_start_idx = w_col[IW-1:0];
        end
    end
`else
    assign w_start_idx = w_lfsr[IW-1:0];
`endif

    assign w_reload = 9'(MIN_INTERVAL) + {1'b0, w_lfsr[7:0] & INTERVAL_MASK};
    assign w_x13    = {1'b0, form_x} + (13'(r_idx) << SP_SH) + 13'(ALIEN_W / 2);
    assign w_y13    = {1'b0, form_y} + 13'(ALIEN_H);

    // The hit cycle registers fire and the spawn point together, so FIRE is the pulse cycle.
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            r_state       <= FC_COUNT;
            r_countdown   <= 9'(MIN_INTERVAL);
            r_idx         <= '0;
            r_wait_fsync  <= 1'b0;
            r_fire        <= 1'b0;
            r_alien_x     <= '0;
            r_alien_y     <= '0;
            r_shooter_idx <= '0;
        end else if (!enable) begin
            r_state <= FC_COUNT;
            r_fire  <= 1'b0;
        end else begin
            case (r_state)
                FC_COUNT: begin
                    if (fsync && r_countdown != 9'd0) begin
                        r_countdown <= r_countdown - 9'd1;
                    end else if (r_countdown == 9'd0 && !bullet_active && alive_mask != '0) begin
                        r_idx   <= w_start_idx;
                        r_state <= FC_SEARCH;
                    end
                end
                FC_SEARCH: begin
                    if (alive_mask == '0) begin
                        r_countdown <= w_reload;
                        r_state     <= FC_COUNT;
                    end else if (alive_mask[r_idx]) begin
                        r_fire        <= 1'b1;
                        r_alien_x     <= clamp12(w_x13, 12'(HRES - 1));
                        r_alien_y     <= clamp12(w_y13, 12'(VRES - 1));
                        r_shooter_idx <= r_idx;
                        r_state       <= FC_FIRE;
                    end else begin
                        r_idx <= (r_idx == IW'(NUM_ALIENS - 1)) ? '0 : r_idx + IW'(1);
                    end
                end
                FC_FIRE: begin
                    r_fire       <= 1'b0;
                    r_wait_fsync <= 1'b0;
                    r_state      <= FC_WAIT;
                end
                FC_WAIT: begin
                    if (bullet_active || (fsync && r_wait_fsync)) begin
                        r_countdown <= w_reload;
                        r_state     <= FC_COUNT;
                    end else if (fsync) begin
                        r_wait_fsync <= 1'b1;
                    end
                end
                default: r_state <= FC_COUNT;
            endcase
        end
    end

    assign fire        = r_fire;
    assign alien_x     = r_alien_x;
    assign alien_y     = r_alien_y;
    assign shooter_idx = r_shooter_idx;
    assign dbg_state   = r_state;
    assign dbg_lfsr    = w_lfsr;
endmodule

// File: tb/tb_alien_fire_ctrl.sv
// Randomized bench for alien_fire_ctrl against a frame-level shot-timing reference model.
module tb_alien_fire_ctrl;
    import alien_fire_ctrl_pkg::*;

    logic        pixel_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fsync = 1'b0;
    logic        enable = 1'b1;
    logic [7:0]  alive_mask = 8'hFF;
    logic [11:0] form_x = 12'd64;
    logic [11:0] form_y = 12'd40;
    logic [11:0] player_x = 12'd0;
    logic        bullet_active = 1'b0;
    logic        fire;
    logic [11:0] alien_x;
    logic [11:0] alien_y;
    logic [2:0]  shooter_idx;
    fire_state_t dbg_state;
    logic [15:0] dbg_lfsr;

    int errors = 0;
    int checks = 0;
    logic [15:0] m_lfsr;
    int m_cd;

    always #5 pixel_clk = ~pixel_clk;

    alien_fire_ctrl dut (
        .pixel_clk     (pixel_clk),
        .rst_n         (rst_n),
        .fsync         (fsync),
        .enable        (enable),
        .alive_mask    (alive_mask),
        .form_x        (form_x),
        .form_y        (form_y),
`ifdef ALIEN_FIRE_AIM_EN
        .player_x      (player_x),
`endif
        .bullet_active (bullet_active),
        .fire          (fire),
        .alien_x       (alien_x),
        .alien_y       (alien_y),
        .shooter_idx   (shooter_idx),
        .dbg_state     (dbg_state),
        .dbg_lfsr      (dbg_lfsr)
    );

    // Reference model: shot timing and spawn point derived from the frame-level rules.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int reload_of(input logic [15:0] v);
        return 30 + int'(v[7:0] & 8'h3F);
    endfunction

    function automatic int start_col();
`ifdef ALIEN_FIRE_AIM_EN
        int c;
        if (player_x < form_x) return 0;
        c = (int'(player_x) - int'(form_x)) / 64;
        return (c > 7) ? 7 : c;
`else
        return int'(m_lfsr[2:0]);
`endif
    endfunction

    function automatic int live_after(input logic [7:0] m, input int s, output int misses);
        for (int k = 0; k < 8; k++) begin
            if (m[(s + k) % 8]) begin
                misses = k;
                return (s + k) % 8;
            end
        end
        misses = -1;
        return -1;
    endfunction

    function automatic int exp_x(input int fx, input int idx);
        int v;
        v = fx + idx * 64 + 16;
        return (v > 639) ? 639 : v;
    endfunction

    function automatic int exp_y(input int fy);
        return (fy + 24 > 479) ? 479 : fy + 24;
    endfunction

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic send_frames(input int n, input int gap, output int early);
        early = 0;
        for (int k = 0; k < n; k++) begin
            fsync = 1'b1;
            tick();
            fsync = 1'b0;
            m_lfsr = lfsr_next(m_lfsr);
            if (fire === 1'b1) early++;
            if (k < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    if (fire === 1'b1) early++;
                end
            end
        end
    endtask

    task automatic wait_fire(input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (fire === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic exit_wait_bullet();
        bullet_active = 1'b1;
        tick();
        m_cd = reload_of(m_lfsr);
        bullet_active = 1'b0;
    endtask

    task automatic exit_wait_timeout();
        fsync = 1'b1;
        tick();
        fsync = 1'b0;
        m_lfsr = lfsr_next(m_lfsr);
        tick();
        tick();
        m_cd = reload_of(m_lfsr);
        fsync = 1'b1;
        tick();
        fsync = 1'b0;
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    // With bullet_active held at countdown 0, step frames until the search would start at column 0.
    task automatic hold_until_start0(output int early);
        early = 0;
        for (int k = 0; k < 100; k++) begin
            if (k > 0 && start_col() == 0) break;
            fsync = 1'b1;
            tick();
            fsync = 1'b0;
            m_lfsr = lfsr_next(m_lfsr);
            if (fire === 1'b1) early++;
            tick();
            tick();
            if (fire === 1'b1) early++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (fire !== 1'b0) begin errors++; $display("FAIL reset_fire: got %0b want 0", fire); end
        checks++; if (alien_x !== 12'd0) begin errors++; $display("FAIL reset_x: got %0d want 0", alien_x); end
        checks++; if (alien_y !== 12'd0) begin errors++; $display("FAIL reset_y: got %0d want 0", alien_y); end
        checks++; if (shooter_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", shooter_idx); end
        checks++; if (dbg_state !== FC_COUNT) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, FC_COUNT); end
        checks++; if (dbg_lfsr !== 16'hACE1) begin errors++; $display("FAIL reset_lfsr: got %h want ace1", dbg_lfsr); end
        rst_n = 1'b1;
        m_lfsr = 16'hACE1;
        m_cd = 30;
    endtask

    task automatic test_basic_shot();
        int early, lat, miss, e_idx;
        alive_mask = 8'hFF;
        form_x = 12'd64;
        form_y = 12'd40;
        player_x = 12'd256;
        for (int s = 0; s < 3; s++) begin
            send_frames(m_cd, 3, early);
            checks++; if (early != 0) begin errors++; $display("FAIL basic_early: got %0d early pulses want 0", early); end
            e_idx = live_after(alive_mask, start_col(), miss);
            wait_fire(20, lat);
            checks++; if (lat != 2 + miss) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, 2 + miss); end
            checks++; if (shooter_idx !== 3'(e_idx)) begin errors++; $display("FAIL basic_idx: got %0d want %0d", shooter_idx, e_idx); end
            checks++; if (alien_x !== 12'(exp_x(64, e_idx))) begin errors++; $display("FAIL basic_x: got %0d want %0d", alien_x, exp_x(64, e_idx)); end
            checks++; if (alien_y !== 12'd64) begin errors++; $display("FAIL basic_y: got %0d want 64", alien_y); end
            tick();
            checks++; if (fire !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %0b want 0", fire); end
            exit_wait_bullet();
        end
    endtask

    task automatic test_random_shots();
        int early, lat, miss, e_idx;
        for (int s = 0; s < 5; s++) begin
            alive_mask = 8'($urandom_range(1, 255));
            form_x = 12'($urandom_range(0, 150));
            form_y = 12'($urandom_range(0, 440));
            player_x = 12'($urandom_range(0, 700));
            send_frames(m_cd, 3, early);
            checks++; if (early != 0) begin errors++; $display("FAIL rand_early: got %0d early pulses want 0", early); end
            e_idx = live_after(alive_mask, start_col(), miss);
            wait_fire(20, lat);
            checks++; if (lat != 2 + miss) begin errors++; $display("FAIL rand_latency: got %0d want %0d", lat, 2 + miss); end
            checks++; if (shooter_idx !== 3'(e_idx)) begin errors++; $display("FAIL rand_idx: got %0d want %0d", shooter_idx, e_idx); end
            checks++; if (alien_x !== 12'(exp_x(int'(form_x), e_idx))) begin errors++; $display("FAIL rand_x: got %0d want %0d", alien_x, exp_x(int'(form_x), e_idx)); end
            checks++; if (alien_y !== 12'(exp_y(int'(form_y)))) begin errors++; $display("FAIL rand_y: got %0d want %0d", alien_y, exp_y(int'(form_y))); end
            tick();
            if ($urandom_range(0, 1) == 1) exit_wait_bullet();
            else exit_wait_timeout();
        end
    endtask

    task automatic test_bullet_hold();
        int early, early2, lat, miss, e_idx;
        alive_mask = 8'b1000_0000;
        form_x = 12'd80;
        form_y = 12'd100;
        player_x = 12'd80;
        bullet_active = 1'b1;
        send_frames(m_cd, 2, early);
        hold_until_start0(early2);
        checks++; if (early + early2 != 0) begin errors++; $display("FAIL hold_blocked: got %0d pulses want 0", early + early2); end
        e_idx = live_after(alive_mask, start_col(), miss);
        bullet_active = 1'b0;
        wait_fire(20, lat);
        checks++; if (lat != 2 + miss) begin errors++; $display("FAIL hold_latency: got %0d want %0d", lat, 2 + miss); end
        checks++; if (shooter_idx !== 3'd7) begin errors++; $display("FAIL hold_idx: got %0d want 7", shooter_idx); end
        checks++; if (alien_x !== 12'(80 + 464)) begin errors++; $display("FAIL hold_x: got %0d want %0d", alien_x, 80 + 464); end
        tick();
        exit_wait_bullet();
    endtask

    task automatic test_mask_drop();
        int early, early2, lat, miss, e_idx;
        alive_mask = 8'b1000_0000;
        player_x = form_x;
        bullet_active = 1'b1;
        send_frames(m_cd, 2, early);
        hold_until_start0(early2);
        bullet_active = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (fire === 1'b1) early++;
        end
        alive_mask = 8'h00;
        tick();
        m_cd = reload_of(m_lfsr);
        if (fire === 1'b1) early++;
        checks++; if (early + early2 != 0) begin errors++; $display("FAIL drop_no_fire: got %0d pulses want 0", early + early2); end
        alive_mask = 8'hFF;
        send_frames(m_cd, 3, early);
        checks++; if (early != 0) begin errors++; $display("FAIL drop_reload_early: got %0d pulses want 0", early); end
        e_idx = live_after(alive_mask, start_col(), miss);
        wait_fire(20, lat);
        checks++; if (lat != 2 + miss) begin errors++; $display("FAIL drop_reload_latency: got %0d want %0d", lat, 2 + miss); end
        checks++; if (shooter_idx !== 3'(e_idx)) begin errors++; $display("FAIL drop_idx: got %0d want %0d", shooter_idx, e_idx); end
        tick();
        exit_wait_bullet();
    endtask

    task automatic test_no_fire();
        int early, early2, early3, lat, miss, e_idx;
        alive_mask = 8'h00;
        send_frames(m_cd, 1, early);
        send_frames(200, 1, early2);
        checks++; if (early + early2 != 0) begin errors++; $display("FAIL nofire_mask0: got %0d pulses want 0", early + early2); end
        enable = 1'b0;
        alive_mask = 8'hFF;
        send_frames(200, 1, early3);
        checks++; if (early3 != 0) begin errors++; $display("FAIL nofire_disabled: got %0d pulses want 0", early3); end
        enable = 1'b1;
        e_idx = live_after(alive_mask, start_col(), miss);
        wait_fire(10, lat);
        checks++; if (lat != 2 + miss) begin errors++; $display("FAIL nofire_reenable_latency: got %0d want %0d", lat, 2 + miss); end
        checks++; if (shooter_idx !== 3'(e_idx)) begin errors++; $display("FAIL nofire_idx: got %0d want %0d", shooter_idx, e_idx); end
        tick();
        exit_wait_bullet();
    endtask

    task automatic test_clamp();
        int early, lat, miss, e_idx;
        alive_mask = 8'b1000_0000;
        form_x = 12'd1200;
        form_y = 12'd4090;
        player_x = 12'd4000;
        send_frames(m_cd, 3, early);
        e_idx = live_after(alive_mask, start_col(), miss);
        wait_fire(20, lat);
        checks++; if (lat != 2 + miss) begin errors++; $display("FAIL clamp_latency: got %0d want %0d", lat, 2 + miss); end
        checks++; if (shooter_idx !== 3'd7) begin errors++; $display("FAIL clamp_idx: got %0d want 7", shooter_idx); end
        checks++; if (alien_x !== 12'd639) begin errors++; $display("FAIL clamp_x: got %0d want 639", alien_x); end
        checks++; if (alien_y !== 12'd479) begin errors++; $display("FAIL clamp_y: got %0d want 479", alien_y); end
        tick();
        exit_wait_bullet();
    endtask

`ifdef ALIEN_FIRE_AIM_EN
    task automatic test_aim();
        int early, lat;
        logic [11:0] px [2] = '{12'd300, 12'd20};
        int          want [2] = '{3, 0};
        alive_mask = 8'hFF;
        form_x = 12'd100;
        form_y = 12'd50;
        for (int s = 0; s < 2; s++) begin
            player_x = px[s];
            send_frames(m_cd, 3, early);
            wait_fire(20, lat);
            checks++; if (lat != 2) begin errors++; $display("FAIL aim_latency: got %0d want 2", lat); end
            checks++; if (shooter_idx !== 3'(want[s])) begin errors++; $display("FAIL aim_idx: got %0d want %0d", shooter_idx, want[s]); end
            checks++; if (alien_x !== 12'(exp_x(100, want[s]))) begin errors++; $display("FAIL aim_x: got %0d want %0d", alien_x, exp_x(100, want[s])); end
            tick();
            exit_wait_bullet();
        end
    endtask
`endif

    task automatic test_reset_search();
        int early, early2;
        alive_mask = 8'b1000_0000;
        form_x = 12'd32;
        form_y = 12'd16;
        player_x = 12'd32;
        bullet_active = 1'b1;
        send_frames(m_cd, 2, early);
        hold_until_start0(early2);
        bullet_active = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (fire === 1'b1) early++;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_lfsr = 16'hACE1;
        m_cd = 30;
        checks++; if (dbg_state !== FC_COUNT) begin errors++; $display("FAIL rstsearch_state: got %0d want %0d", dbg_state, FC_COUNT); end
        checks++; if (alien_x !== 12'd0 || alien_y !== 12'd0) begin errors++; $display("FAIL rstsearch_xy: got %0d,%0d want 0,0", alien_x, alien_y); end
        checks++; if (shooter_idx !== 3'd0) begin errors++; $display("FAIL rstsearch_idx: got %0d want 0", shooter_idx); end
        checks++; if (dbg_lfsr !== 16'hACE1) begin errors++; $display("FAIL rstsearch_lfsr: got %h want ace1", dbg_lfsr); end
        for (int k = 0; k < 12; k++) begin
            if (fire === 1'b1) early++;
            tick();
        end
        checks++; if (early + early2 != 0) begin errors++; $display("FAIL rstsearch_no_fire: got %0d pulses want 0", early + early2); end
    endtask

    initial begin
        test_reset();
        test_basic_shot();
        test_random_shots();
        test_bullet_hold();
        test_mask_drop();
        test_no_fire();
        test_clamp();
`ifdef ALIEN_FIRE_AIM_EN
        test_aim();
`endif
        test_reset_search();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
